// File: rtl/lpddr3_cs_n_lane_ctrl.sv
// lpddr3_cs_n_lane_ctrl: fabric-side driver for the LPDDR3 CS0_N output lane.
// Formats slot-indexed command strobes into 4-phase active-low TX/OE words
// and sequences the lane's dynamic delay line (MOVE/DIRECTION/LOAD).
// Optional build macro CS_N_LANE_STATS_EN adds CMD_CNT/MOVE_CNT counters.
module lpddr3_cs_n_lane_ctrl #(
    parameter int unsigned TX_LATENCY   = 1,
    parameter int unsigned DLY_MAX_TAPS = 127,
    parameter int unsigned MOVE_GAP     = 3
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       OE_ENABLE,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_SLOT,
    input  logic       CMD_2T,
    output logic [3:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    input  logic       DLY_REQ,
    input  logic       DLY_DIR,
    input  logic [6:0] DLY_STEPS,
    input  logic       DLY_LOAD_REQ,
    output logic       DLY_BUSY,
    output logic       DLY_DONE,
    output logic       DLY_ERR,
    output logic [6:0] DLY_TAP,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       DELAY_LINE_LOAD_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0
`ifdef CS_N_LANE_STATS_EN
    ,
    output logic [15:0] CMD_CNT,
    output logic [15:0] MOVE_CNT
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIR_SETUP,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } dly_state_e;

    // ---------------- command formatter ----------------
    logic       carry_q;
    logic       carry_d;
    logic       accept;
    logic [3:0] word_d;
    logic [3:0] tx_pipe_q [TX_LATENCY];
    logic [3:0] oe_pipe_q [TX_LATENCY];

    assign CMD_READY = OE_ENABLE & ~carry_q;
    assign accept    = CMD_VALID & CMD_READY;

    // Build the per-cycle CS_N word; a 2T strobe in slot 3 spills into phase 0 of the next word
    always_comb begin
        word_d  = '1;
        carry_d = 1'b0;
        if (carry_q) begin
            word_d[0] = 1'b0;
        end
        if (accept) begin
            word_d[CMD_SLOT] = 1'b0;
            if (CMD_2T) begin
                if (CMD_SLOT == 2'd3) begin
                    carry_d = 1'b1;
                end else begin
                    word_d[CMD_SLOT + 2'd1] = 1'b0;
                end
            end
        end
    end

    // Carry flag and TX/OE latency pipeline, reset to idle words
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            carry_q <= 1'b0;
            for (int unsigned i = 0; i < TX_LATENCY; i++) begin
                tx_pipe_q[i] <= '1;
                oe_pipe_q[i] <= '0;
            end
        end else begin
            carry_q      <= carry_d;
            tx_pipe_q[0] <= word_d;
            oe_pipe_q[0] <= {4{OE_ENABLE}};
            for (int unsigned i = 1; i < TX_LATENCY; i++) begin
                tx_pipe_q[i] <= tx_pipe_q[i-1];
                oe_pipe_q[i] <= oe_pipe_q[i-1];
            end
        end
    end

    assign TX_DATA_0 = tx_pipe_q[TX_LATENCY-1];
    assign OE_DATA_0 = oe_pipe_q[TX_LATENCY-1];

    // ---------------- delay-line sequencer ----------------
    dly_state_e state_q;
    logic       dir_q;
    logic       move_q;
    logic       load_q;
    logic       done_q;
    logic       err_q;
    logic [6:0] tap_q;
    logic [6:0] rem_q;
    logic [3:0] gap_q;
    logic       can_move;

    // The move decision is taken on entry to MOVE so the pulse is registered
    assign can_move = dir_q ? (tap_q < 7'(DLY_MAX_TAPS)) : (tap_q != '0);

    // Delay FSM: registered MOVE/DIRECTION/LOAD/DONE, tap tracking and sticky error
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            move_q  <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tap_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
        end else begin
            move_q <= 1'b0;
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (DLY_LOAD_REQ) begin
                        load_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else if (DLY_REQ) begin
                        if (DLY_STEPS == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            dir_q   <= DLY_DIR;
                            rem_q   <= DLY_STEPS;
                            state_q <= ST_DIR_SETUP;
                        end
                    end
                end
                ST_LOAD: begin
                    tap_q   <= '0;
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DIR_SETUP: begin
                    if (can_move) begin
                        move_q  <= 1'b1;
                        tap_q   <= dir_q ? tap_q + 7'd1 : tap_q - 7'd1;
                        rem_q   <= rem_q - 7'd1;
                        state_q <= ST_MOVE;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_MOVE: begin
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        gap_q   <= 4'(MOVE_GAP - 1);
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - 4'd1;
                    end else if (rem_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (can_move) begin
                        move_q  <= 1'b1;
                        tap_q   <= dir_q ? tap_q + 7'd1 : tap_q - 7'd1;
                        rem_q   <= rem_q - 7'd1;
                        state_q <= ST_MOVE;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dir_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign DLY_BUSY               = (state_q != ST_IDLE);
    assign DLY_DONE               = done_q;
    assign DLY_ERR                = err_q;
    assign DLY_TAP                = tap_q;
    assign DELAY_LINE_MOVE_0      = move_q;
    assign DELAY_LINE_DIRECTION_0 = dir_q;
    assign DELAY_LINE_LOAD_0      = load_q;

`ifdef CS_N_LANE_STATS_EN
    logic [15:0] cmd_cnt_q;
    logic [15:0] move_cnt_q;

    // Accepted-command counter wraps; move-pulse counter saturates
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            cmd_cnt_q  <= '0;
            move_cnt_q <= '0;
        end else begin
            if (accept) begin
                cmd_cnt_q <= cmd_cnt_q + 16'd1;
            end
            if (move_q && (move_cnt_q != '1)) begin
                move_cnt_q <= move_cnt_q + 16'd1;
            end
        end
    end

    assign CMD_CNT  = cmd_cnt_q;
    assign MOVE_CNT = move_cnt_q;
`endif

endmodule

// File: tb/tb_lpddr3_cs_n_lane_ctrl.sv
// Scoreboard bench for lpddr3_cs_n_lane_ctrl: stimulus pushes expected TX/OE
// words and expected delay-sequence outcomes; monitors pop and compare.
module tb_lpddr3_cs_n_lane_ctrl;

    localparam int LAT = 1;
    localparam int GAP = 3;

    logic       clk = 1'b0;
    logic       ARST_N = 1'b0;
    logic       OE_ENABLE = 1'b0;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic [1:0] CMD_SLOT = '0;
    logic       CMD_2T = 1'b0;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       DLY_REQ = 1'b0;
    logic       DLY_DIR = 1'b0;
    logic [6:0] DLY_STEPS = '0;
    logic       DLY_LOAD_REQ = 1'b0;
    logic       DLY_BUSY;
    logic       DLY_DONE;
    logic       DLY_ERR;
    logic [6:0] DLY_TAP;
    logic       MOVE, DIRECTION, LOAD;
    logic       OOR = 1'b0;
`ifdef CS_N_LANE_STATS_EN
    logic [15:0] CMD_CNT, MOVE_CNT;
`endif

    lpddr3_cs_n_lane_ctrl #(.TX_LATENCY(LAT), .DLY_MAX_TAPS(127), .MOVE_GAP(GAP)) dut (
        .FAB_CLK(clk), .ARST_N(ARST_N), .OE_ENABLE(OE_ENABLE),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_SLOT(CMD_SLOT), .CMD_2T(CMD_2T),
        .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
        .DLY_REQ(DLY_REQ), .DLY_DIR(DLY_DIR), .DLY_STEPS(DLY_STEPS), .DLY_LOAD_REQ(DLY_LOAD_REQ),
        .DLY_BUSY(DLY_BUSY), .DLY_DONE(DLY_DONE), .DLY_ERR(DLY_ERR), .DLY_TAP(DLY_TAP),
        .DELAY_LINE_MOVE_0(MOVE), .DELAY_LINE_DIRECTION_0(DIRECTION),
        .DELAY_LINE_LOAD_0(LOAD), .DELAY_LINE_OUT_OF_RANGE_0(OOR)
`ifdef CS_N_LANE_STATS_EN
        , .CMD_CNT(CMD_CNT), .MOVE_CNT(MOVE_CNT)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct { int cyc; logic [3:0] tx; logic [3:0] oe; } tx_exp_t;
    typedef struct { logic [6:0] tap; logic err; int pulses; int loads; logic dir; } dly_exp_t;
    tx_exp_t  txq[$];
    dly_exp_t dq[$];

    int   pulses = 0;
    int   loads = 0;
    int   dones = 0;
    int   last_move = 0;
    logic prev_dir = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TX/OE monitor
    always @(negedge clk) begin
        if (ARST_N && txq.size() > 0 && txq[0].cyc <= cyc) begin
            tx_exp_t e;
            e = txq.pop_front();
            tests++;
            if (TX_DATA_0 !== e.tx || OE_DATA_0 !== e.oe || e.cyc != cyc) begin
                fails++;
                $display("FAIL tx_word@%0d: got tx=%b oe=%b expected tx=%b oe=%b (tag %0d)",
                         cyc, TX_DATA_0, OE_DATA_0, e.tx, e.oe, e.cyc);
            end
        end
    end

    // Delay-line monitor
    always @(negedge clk) begin
        if (!ARST_N) begin
            pulses = 0;
            loads  = 0;
        end else begin
            if (MOVE) begin
                if (dq.size() > 0) begin
                    tests++;
                    if (DIRECTION !== dq[0].dir || (pulses == 0 && prev_dir !== dq[0].dir) ||
                        (pulses > 0 && cyc - last_move != GAP + 1)) begin
                        fails++;
                        $display("FAIL move_pulse@%0d: dir=%b prev_dir=%b spacing=%0d expected dir=%b spacing=%0d",
                                 cyc, DIRECTION, prev_dir, cyc - last_move, dq[0].dir, GAP + 1);
                    end
                end
                pulses++;
                last_move = cyc;
            end
            if (LOAD) loads++;
            if (DLY_DONE) begin
                tests++;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL dly_done: unexpected DLY_DONE at cycle %0d", cyc);
                end else begin
                    dly_exp_t d;
                    d = dq.pop_front();
                    if (DLY_TAP !== d.tap || DLY_ERR !== d.err || pulses != d.pulses || loads != d.loads) begin
                        fails++;
                        $display("FAIL dly_done: got tap=%0d err=%b pulses=%0d loads=%0d expected tap=%0d err=%b pulses=%0d loads=%0d",
                                 DLY_TAP, DLY_ERR, pulses, loads, d.tap, d.err, d.pulses, d.loads);
                    end
                end
                pulses = 0;
                loads  = 0;
                dones++;
            end
            prev_dir = DIRECTION;
        end
    end

    task automatic step(input logic v, input logic [1:0] s, input logic t2, input logic oe,
                        input logic [3:0] etx, input logic [3:0] eoe, input logic erdy);
        tx_exp_t e;
        @(posedge clk); #1;
        CMD_VALID = v; CMD_SLOT = s; CMD_2T = t2; OE_ENABLE = oe;
        #1;
        chk("cmd_ready", 32'(CMD_READY), 32'(erdy));
        e.cyc = cyc + LAT; e.tx = etx; e.oe = eoe;
        txq.push_back(e);
    endtask

    task automatic dly(input logic ld, input logic rq, input logic dir, input logic [6:0] steps,
                       input int poke, input int oor_after,
                       input logic [6:0] etap, input logic eerr, input int ep, input int el);
        dly_exp_t d;
        int start;
        d.tap = etap; d.err = eerr; d.pulses = ep; d.loads = el; d.dir = dir;
        dq.push_back(d);
        start = dones;
        @(posedge clk); #1;
        DLY_LOAD_REQ = ld; DLY_REQ = rq; DLY_DIR = dir; DLY_STEPS = steps;
        for (int k = 0; k < 300 && dones == start; k++) begin
            @(posedge clk); #1;
            DLY_REQ = 1'b0;
            DLY_LOAD_REQ = (poke != 0 && k == poke);
            if (oor_after != 0 && pulses >= oor_after) OOR = 1'b1;
        end
        OOR = 1'b0;
        DLY_LOAD_REQ = 1'b0;
        if (dones == start) begin
            tests++; fails++;
            $display("FAIL dly_timeout: no DLY_DONE, got none expected one");
            if (dq.size() > 0) void'(dq.pop_front());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx", 32'(TX_DATA_0), 32'hF);
        chk("rst_oe", 32'(OE_DATA_0), 32'h0);
        chk("rst_busy_done_err", 32'({DLY_BUSY, DLY_DONE, DLY_ERR, MOVE, DIRECTION, LOAD}), 32'h0);
        chk("rst_tap", 32'(DLY_TAP), 32'h0);
        @(negedge clk);
        ARST_N = 1'b1;

        // command formatter vectors
        step(1'b0, 2'd0, 1'b0, 1'b1, 4'hF,    4'hF, 1'b1);
        step(1'b1, 2'd2, 1'b0, 1'b1, 4'b1011, 4'hF, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 4'hF,    4'hF, 1'b1);
        step(1'b1, 2'd3, 1'b1, 1'b1, 4'b0111, 4'hF, 1'b1);
        step(1'b1, 2'd1, 1'b0, 1'b1, 4'b1110, 4'hF, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b1, 4'b1101, 4'hF, 1'b1);
        step(1'b1, 2'd0, 1'b1, 1'b1, 4'b1100, 4'hF, 1'b1);
        step(1'b1, 2'd2, 1'b1, 1'b1, 4'b0011, 4'hF, 1'b1);
        step(1'b1, 2'd1, 1'b0, 1'b0, 4'hF,    4'h0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 4'hF,    4'h0, 1'b0);
        step(1'b1, 2'd3, 1'b1, 1'b1, 4'b0111, 4'hF, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 4'b1110, 4'h0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b1, 4'hF,    4'hF, 1'b1);
        @(posedge clk); #1;
        CMD_VALID = 1'b0;
        repeat (3) @(posedge clk);

        // delay sequencer vectors: ld rq dir steps poke oor | tap err pulses loads
        dly(1'b0, 1'b1, 1'b1, 7'd5,  3, 0, 7'd5, 1'b0, 5, 0);
        dly(1'b0, 1'b1, 1'b0, 7'd3,  0, 0, 7'd2, 1'b0, 3, 0);
        dly(1'b0, 1'b1, 1'b0, 7'd4,  0, 0, 7'd0, 1'b1, 2, 0);
        dly(1'b1, 1'b1, 1'b1, 7'd5,  0, 0, 7'd0, 1'b0, 0, 1);
        dly(1'b0, 1'b1, 1'b1, 7'd0,  0, 0, 7'd0, 1'b0, 0, 0);
        dly(1'b0, 1'b1, 1'b1, 7'd10, 0, 3, 7'd3, 1'b1, 3, 0);
        dly(1'b1, 1'b0, 1'b0, 7'd0,  0, 0, 7'd0, 1'b0, 0, 1);

        // asynchronous reset in the middle of a move
        @(posedge clk); #1;
        DLY_REQ = 1'b1; DLY_DIR = 1'b1; DLY_STEPS = 7'd10;
        @(posedge clk); #1;
        DLY_REQ = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk); #1;
            if (MOVE && pulses >= 2) seen = 1'b1;
        end
        chk("mid_move_reached", 32'(seen), 32'h1);
        ARST_N = 1'b0;
        #1;
        chk("arst_move", 32'(MOVE), 32'h0);
        chk("arst_flags", 32'({DLY_BUSY, DLY_DONE, DLY_ERR, DIRECTION, LOAD}), 32'h0);
        chk("arst_tap", 32'(DLY_TAP), 32'h0);
        chk("arst_tx_oe", 32'({TX_DATA_0, OE_DATA_0}), 32'hF0);
        @(posedge clk); #2;
        ARST_N = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'({DLY_BUSY, MOVE}), 32'h0);

        repeat (4) @(posedge clk);
        if (txq.size() != 0 || dq.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", txq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lpddr3_cs_n_lane_ctrl.md
Name: lpddr3_cs_n_lane_ctrl

Overview:
- Fabric-side driver for the LPDDR3 CS0_N output lane.
- Sits directly upstream of the CS_N I/O-delay block, clocked on FAB_CLK.
- Converts slot-indexed command strobes into 4-phase active-low TX_DATA_0/OE_DATA_0 words.
- Sequences the lane's dynamic delay line (MOVE/DIRECTION/LOAD) on request and tracks the tap position.

Parameters:
TX_LATENCY, 1, register stages from command accept to TX_DATA_0/OE_DATA_0; legal 1..4
DLY_MAX_TAPS, 127, highest legal tap index for the tracked tap counter
MOVE_GAP, 3, idle cycles forced after each DELAY_LINE_MOVE_0 pulse; legal 1..15

Ports:
FAB_CLK  in  1  the single clock
ARST_N  in  1  asynchronous active-low reset
OE_ENABLE  in  1  lane drive enable
CMD_VALID  in  1  command strobe request
CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY
CMD_SLOT  in  2  phase (0..3) in which CS_N asserts; bit0 transmitted first
CMD_2T  in  1  assert CS_N for two consecutive phases
TX_DATA_0  out  4  per-phase CS_N level to IOD
OE_DATA_0  out  4  per-phase output enable to IOD
DLY_REQ  in  1  start relative move
DLY_DIR  in  1  1 = increment tap, 0 = decrement
DLY_STEPS  in  7  number of taps to move
DLY_LOAD_REQ  in  1  reload delay line to tap 0
DLY_BUSY  out  1  sequencer not idle
DLY_DONE  out  1  one-cycle completion pulse
DLY_ERR  out  1  sticky range error
DLY_TAP  out  7  tracked tap index
DELAY_LINE_MOVE_0  out  1  move pulse to IOD
DELAY_LINE_DIRECTION_0  out  1  direction to IOD
DELAY_LINE_LOAD_0  out  1  load pulse to IOD
DELAY_LINE_OUT_OF_RANGE_0  in  1  range flag from IOD

Behaviour:
- Reset (ARST_N low, asynchronous): TX_DATA_0=4'hF, OE_DATA_0=4'h0, pipeline filled with idle, carry=0, DLY_BUSY=0, DLY_DONE=0, DLY_ERR=0, DLY_TAP=0, MOVE/DIRECTION/LOAD=0, FSM=IDLE.
- Mid-operation reset aborts any sequence; MOVE/LOAD drop immediately.
- CMD_READY is combinational: OE_ENABLE & ~carry.
- Formatter, per cycle: word = 4'hF.
  - On accept, word[CMD_SLOT]=0.
  - If CMD_2T, also word[CMD_SLOT+1]=0.
  - If CMD_SLOT=3 and CMD_2T: set carry. Next cycle word[0]=0, carry clears, CMD_READY=0 for that cycle.
- Word and {4{OE_ENABLE}} pass through TX_LATENCY registers. An accept at edge N appears on TX_DATA_0 at edge N+TX_LATENCY-1 output (i.e. visible TX_LATENCY cycles after accept). OE_DATA_0 is aligned to the same word.
- OE_ENABLE falling while carry=1: the carry word is still emitted; its OE phase follows OE_ENABLE.
- Delay FSM states: IDLE, LOAD, DIR_SETUP, MOVE, GAP, DONE.
- IDLE:
  - DLY_LOAD_REQ -> LOAD. Takes priority if DLY_LOAD_REQ and DLY_REQ arrive together.
  - Else DLY_REQ: DLY_STEPS=0 -> DONE; otherwise latch DIR/STEPS -> DIR_SETUP.
  - Requests arriving while DLY_BUSY are ignored (not queued).
- LOAD: DELAY_LINE_LOAD_0=1 for one cycle, DLY_TAP:=0, DLY_ERR:=0 -> DONE.
- DIR_SETUP: DELAY_LINE_DIRECTION_0 = latched DIR, one cycle before the first MOVE. Direction is held until the return to IDLE.
- MOVE:
  - If the tap would go past DLY_MAX_TAPS (inc) or below 0 (dec): DLY_ERR:=1, no pulse, -> DONE.
  - Else DELAY_LINE_MOVE_0=1 for one cycle, DLY_TAP ±1, remaining-1 -> GAP.
- GAP: MOVE_GAP cycles. Then remaining=0 -> DONE, else -> MOVE.
- DELAY_LINE_OUT_OF_RANGE_0 sampled high in MOVE or GAP: DLY_ERR:=1, remaining steps dropped, -> DONE. DLY_TAP keeps steps actually issued.
- DONE: DLY_DONE=1 for one cycle -> IDLE.
- DLY_BUSY=1 in every state except IDLE.
- DLY_ERR clears only via LOAD or reset.

Optional Feature:
- Macro CS_N_LANE_STATS_EN.
- When defined: adds outputs CMD_CNT[15:0] (accepted commands, wraps at 16'hFFFF->0) and MOVE_CNT[15:0] (MOVE pulses issued, saturating at 16'hFFFF). Both are cleared by reset.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, OE_ENABLE=1, TX_LATENCY=1, accept SLOT=2, 2T=0 -> next-cycle TX_DATA_0=4'b1011, OE_DATA_0=4'hF; then 4'hF.
- Accept SLOT=3, 2T=1 -> TX_DATA_0=4'b0111 then 4'b1110; CMD_READY=0 during the carry cycle; a CMD_VALID held there is accepted one cycle later.
- OE_ENABLE=0 -> CMD_READY=0, OE_DATA_0=4'h0 after TX_LATENCY cycles, TX_DATA_0=4'hF.
- DLY_REQ DIR=1 STEPS=5, MOVE_GAP=3 -> DIRECTION high one cycle before the first MOVE; 5 MOVE pulses spaced 4 cycles apart; DLY_TAP=5; single DLY_DONE; DLY_ERR=0.
- DLY_TAP=2, DLY_REQ DIR=0 STEPS=4 -> 2 pulses, DLY_TAP=0, DLY_ERR=1; then DLY_LOAD_REQ with DLY_REQ same cycle -> LOAD pulse only, DLY_ERR=0.
- OUT_OF_RANGE asserted after the 3rd pulse of a 10-step move -> no further pulses, DLY_TAP=+3, DLY_ERR=1; ARST_N pulsed mid-move -> MOVE low immediately, all outputs at reset values.
